// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU: captures decoded fields,
// forwards EX/MEM and MEM/WB results into rs/rt, and selects ALU operands.

// One source operand's forwarding mux (EX/MEM beats MEM/WB, r0 never forwarded)
module id_ex_fwd #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] fwd_data
);
  logic nz;
  assign nz = (src_addr != '0);

  // pick the youngest in-flight producer of src_addr, else the register-file value
  always_comb begin
    fwd_data = src_data;
    if (exmem_reg_write && nz && (exmem_rd == src_addr))
      fwd_data = exmem_result;
    else if (memwb_reg_write && nz && (memwb_rd == src_addr))
      fwd_data = memwb_result;
  end
endmodule

module id_ex_alu_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm32,
  input  logic [4:0]    id_shamt,
  input  logic          id_a_sel,
  input  logic [1:0]    id_b_sel,
  input  logic [3:0]    id_alu_op,
  input  logic [AW-1:0] id_rd_addr,
  input  logic          id_reg_write,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_valid,
  output logic [AW-1:0] ex_rd,
  output logic          ex_reg_write
);
  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic [3:0]    alu_op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm32;
    logic [4:0]    shamt;
    logic          a_sel;
    logic [1:0]    b_sel;
  } stage_t;

  stage_t stage_d, stage_q;

  // flush wins over stall; an all-zero bubble decodes as a harmless add of 0+0
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid     = id_valid;
      stage_d.reg_write = id_reg_write & id_valid;
      stage_d.alu_op    = id_alu_op;
      stage_d.rd        = id_rd_addr;
      stage_d.rs_addr   = id_rs_addr;
      stage_d.rt_addr   = id_rt_addr;
      stage_d.rs_data   = id_rs_data;
      stage_d.rt_data   = id_rt_data;
      stage_d.imm32     = id_imm32;
      stage_d.shamt     = id_shamt;
      stage_d.a_sel     = id_a_sel;
      stage_d.b_sel     = id_b_sel;
    end
  end

  // stage register; reset discards any in-flight instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stage_q <= '0;
    else          stage_q <= stage_d;
  end

  // forwarding is re-evaluated every cycle, so a stalled instruction picks up
  // results that land while it waits
  logic [DW-1:0] fwd_rs, fwd_rt;

  id_ex_fwd #(.DW(DW), .AW(AW)) u_fwd_rs (
    .src_addr(stage_q.rs_addr), .src_data(stage_q.rs_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .fwd_data(fwd_rs)
  );

  id_ex_fwd #(.DW(DW), .AW(AW)) u_fwd_rt (
    .src_addr(stage_q.rt_addr), .src_data(stage_q.rt_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .fwd_data(fwd_rt)
  );

  // operand select: A may take rt for shifts, B may take imm, shamt or rs
  always_comb begin
    alu_a = stage_q.a_sel ? fwd_rt : fwd_rs;
    unique case (stage_q.b_sel)
      2'b00:   alu_b = fwd_rt;
      2'b01:   alu_b = stage_q.imm32;
      2'b10:   alu_b = {{(DW-5){1'b0}}, stage_q.shamt};
      default: alu_b = fwd_rs;
    endcase
  end

  assign ex_store_data = fwd_rt;
  assign alu_op        = stage_q.alu_op;
  assign ex_rd         = stage_q.rd;
  assign ex_valid      = stage_q.valid;
  assign ex_reg_write  = stage_q.reg_write;
endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed bench for id_ex_alu_stage with hand-computed expectations.
module tb_id_ex_alu_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm32;
  logic        id_a_sel, id_reg_write;
  logic [1:0]  id_b_sel;
  logic [3:0]  id_alu_op;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_reg_write;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_alu_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32),
    .id_shamt(id_shamt), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_alu_op(id_alu_op), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                      input logic [4:0] rt, input logic [31:0] rtd, input logic [31:0] imm,
                      input logic [4:0] sh, input logic asel, input logic [1:0] bsel,
                      input logic [3:0] op, input logic [4:0] rd, input logic rw);
    id_valid = v; id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
    id_imm32 = imm; id_shamt = sh; id_a_sel = asel; id_b_sel = bsel; id_alu_op = op;
    id_rd_addr = rd; id_reg_write = rw;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                     input logic mw, input logic [4:0] mrd, input logic [31:0] mr);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = er;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mr;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    fwd(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    reset_n = 1'b1;

    // plain capture
    load(1, 5'd3, 32'h5, 5'd4, 32'h7, 32'h0, 0, 0, 2'b00, 4'd1, 5'd8, 1);
    tick();
    chk("cap_alu_a", alu_a, 32'h5);
    chk("cap_alu_b", alu_b, 32'h7);
    chk("cap_alu_op", {28'b0, alu_op}, 32'h1);
    chk("cap_ex_rd", {27'b0, ex_rd}, 32'h8);
    chk("cap_ex_rw", {31'b0, ex_reg_write}, 32'h1);
    chk("cap_ex_valid", {31'b0, ex_valid}, 32'h1);
    chk("cap_store", ex_store_data, 32'h7);

    // forwarding priority on rs=9, rt=10
    load(1, 5'd9, 32'h1111, 5'd10, 32'h2222, 32'h0, 0, 0, 2'b00, 4'd2, 5'd11, 1);
    tick();
    fwd(1, 5'd9, 32'hAAAA_0000, 1, 5'd9, 32'h5555_0000);
    #1 chk("fwd_both", alu_a, 32'hAAAA_0000);
    exmem_reg_write = 1'b0;
    #1 chk("fwd_memwb", alu_a, 32'h5555_0000);
    memwb_reg_write = 1'b0;
    #1 chk("fwd_none", alu_a, 32'h1111);
    fwd(1, 5'd10, 32'hCAFE_0001, 1, 5'd9, 32'hBEEF_0002);
    #1 chk("fwd_rt_b", alu_b, 32'hCAFE_0001);
    chk("fwd_rt_store", ex_store_data, 32'hCAFE_0001);
    chk("fwd_rs_mw", alu_a, 32'hBEEF_0002);
    fwd(0, 0, 0, 0, 0, 0);

    // register zero never forwarded
    load(1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 0, 0, 2'b00, 4'd0, 5'd1, 1);
    tick();
    fwd(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hEEEE_EEEE);
    #1 chk("r0_alu_a", alu_a, 32'h0);
    chk("r0_alu_b", alu_b, 32'h0);
    fwd(0, 0, 0, 0, 0, 0);

    // shift select: A=rt, B=shamt
    load(1, 5'd6, 32'h1234, 5'd5, 32'h8000_0001, 32'h0, 5'd4, 1, 2'b10, 4'd7, 5'd12, 1);
    tick();
    chk("sh_alu_a", alu_a, 32'h8000_0001);
    chk("sh_alu_b", alu_b, 32'h4);
    chk("sh_alu_op", {28'b0, alu_op}, 32'h7);

    // stall two cycles while id_* changes
    stall = 1'b1;
    load(1, 5'd20, 32'hDEAD, 5'd21, 32'hBEEF, 32'h99, 5'd9, 0, 2'b01, 4'd3, 5'd22, 0);
    tick();
    tick();
    chk("stl_alu_a", alu_a, 32'h8000_0001);
    chk("stl_alu_b", alu_b, 32'h4);
    chk("stl_alu_op", {28'b0, alu_op}, 32'h7);
    chk("stl_ex_rd", {27'b0, ex_rd}, 32'd12);
    // held instruction still sees new forwards
    fwd(1, 5'd5, 32'h0F0F_0F0F, 0, 0, 0);
    #1 chk("stl_refwd", alu_a, 32'h0F0F_0F0F);
    fwd(0, 0, 0, 0, 0, 0);

    // stall with flush: flush wins
    flush = 1'b1;
    tick();
    chk("fl_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("fl_ex_rw", {31'b0, ex_reg_write}, 32'h0);
    chk("fl_alu_op", {28'b0, alu_op}, 32'h0);
    chk("fl_alu_b", alu_b, 32'h0);
    stall = 1'b0; flush = 1'b0;

    // immediate B and invalid instruction gating reg_write
    load(0, 5'd2, 32'h3, 5'd4, 32'h5, 32'hFFFF_FF80, 0, 0, 2'b01, 4'd9, 5'd7, 1);
    tick();
    chk("imm_alu_b", alu_b, 32'hFFFF_FF80);
    chk("inv_ex_rw", {31'b0, ex_reg_write}, 32'h0);
    chk("inv_ex_valid", {31'b0, ex_valid}, 32'h0);

    // B = rs for variable shifts
    load(1, 5'd2, 32'h1F, 5'd4, 32'h55, 32'h0, 0, 1, 2'b11, 4'd8, 5'd7, 1);
    tick();
    chk("var_alu_a", alu_a, 32'h55);
    chk("var_alu_b", alu_b, 32'h1F);

    // asynchronous reset mid-cycle with a valid instruction held
    #2 reset_n = 1'b0;
    #1;
    chk("arst_alu_a", alu_a, 32'h0);
    chk("arst_alu_b", alu_b, 32'h0);
    chk("arst_op", {28'b0, alu_op}, 32'h0);
    chk("arst_store", ex_store_data, 32'h0);
    chk("arst_ctl", {29'b0, ex_valid, ex_reg_write, |ex_rd}, 32'h0);
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
